// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues single-outstanding reads to instruction memory,
// and buffers {instruction, PC} pairs in a small FIFO for decode/execute.
module instr_fetch_queue #(
    parameter int PC_W = 12,
    parameter int INSTR_W = 19,
    parameter int DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    instr_pc_o,
    output logic [PC_W-1:0]    instr_pc_plus1_o,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PC_W-1:0]    fetchPc_q, fetchPc_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic               req_q, req_d;
    logic               squash_q, squash_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [INSTR_W-1:0] instrMem [DEPTH];
    logic [PC_W-1:0]    pcMem [DEPTH];

    logic complete;
    logic pop;
    logic push;
    logic pendingAfter;

    always_comb begin
        complete     = req_q & imem_ack_i;
        pop          = (count_q != '0) & instr_ready_i;
        push         = complete & ~squash_q & ~redirect_i;
        pendingAfter = req_q & ~complete;

        count_d   = count_q;
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        fetchPc_d = fetchPc_q;

        if (redirect_i) begin
            count_d   = '0;
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            fetchPc_d = redirect_pc_i;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            rdPtr_d = rdPtr_q + PTR_W'(pop);
            wrPtr_d = wrPtr_q + PTR_W'(push);
            if (push) begin
                fetchPc_d = addr_q + PC_W'(1);
            end
        end

        // A read left in flight by a redirect must complete at its old address and be dropped.
        squash_d = pendingAfter & (redirect_i | squash_q);

        req_d  = 1'b0;
        addr_d = addr_q;
        if (pendingAfter) begin
            req_d = 1'b1;
        end else if (count_d < FULL) begin
            req_d  = 1'b1;
            addr_d = fetchPc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetchPc_q <= RESET_PC;
            addr_q    <= RESET_PC;
            req_q     <= 1'b0;
            squash_q  <= 1'b0;
            count_q   <= '0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
        end else begin
            fetchPc_q <= fetchPc_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            squash_q  <= squash_d;
            count_q   <= count_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instrMem[wrPtr_q] <= imem_rdata_i;
            pcMem[wrPtr_q]    <= addr_q;
        end
    end

    assign imem_req_o       = req_q;
    assign imem_addr_o      = addr_q;
    assign instr_valid_o    = (count_q != '0);
    assign instr_o          = instrMem[rdPtr_q];
    assign instr_pc_o       = pcMem[rdPtr_q];
    assign instr_pc_plus1_o = pcMem[rdPtr_q] + PC_W'(1);

endmodule
